redirect_seq: RTL and testbench



---
 rtl/pipeline_types.sv | 17 +
 rtl/redirect_prio_enc.sv | 39 +++
 rtl/redirect_seq.sv | 141 ++++++++++++++
 tb/tb_redirect_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_types.sv
// Shared types and flush/pause masks for the back-end redirect sequencer.
`timescale 1ns/1ps
package pipeline_types;

    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT, IDLE} redirect_state_t;
    typedef enum logic [1:0] {RC_EXC, RC_ERTN, RC_BR} redirect_cause_t;

    localparam logic [7:0] FLUSH_MASK_FULL = 8'h7F;
    localparam logic [7:0] FLUSH_MASK_BR   = 8'h1F;
    localparam logic [7:0] PAUSE_MASK_IDLE = 8'h7F;

    // A branch only squashes the front end; exception/ertn flush everything but wb.
    function automatic logic [7:0] cause_mask(input redirect_cause_t cause);
        return (cause == RC_BR) ? FLUSH_MASK_BR : FLUSH_MASK_FULL;
    endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Combinational priority pick of redirect cause and target: exc > ertn > branch.
`timescale 1ns/1ps
module redirect_prio_enc
    import pipeline_types::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  exc_req,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  ertn_req,
    input  logic [ADDR_WIDTH-1:0] ertn_target,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  branch_en,
    output logic                  pick_valid,
    output redirect_cause_t       pick_cause,
    output logic [ADDR_WIDTH-1:0] pick_target
);

    always_comb begin
        pick_valid  = 1'b0;
        pick_cause  = RC_EXC;
        pick_target = '0;
        if (exc_req) begin
            pick_valid  = 1'b1;
            pick_cause  = RC_EXC;
            pick_target = exc_target;
        end else if (ertn_req) begin
            pick_valid  = 1'b1;
            pick_cause  = RC_ERTN;
            pick_target = ertn_target;
        end else if (branch_req && branch_en) begin
            pick_valid  = 1'b1;
            pick_cause  = RC_BR;
            pick_target = branch_target;
        end
    end

endmodule

// File: rtl/redirect_seq.sv
// Multi-cycle redirect sequencer: registered flush for FLUSH_HOLD cycles, then a held redirect PC.
`timescale 1ns/1ps
module redirect_seq
    import pipeline_types::*;
#(
    parameter int PIPE_WIDTH = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int FLUSH_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exc_req,
    input  logic [ADDR_WIDTH-1:0] exc_target,
    input  logic                  ertn_req,
    input  logic [ADDR_WIDTH-1:0] ertn_target,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  idle_req,
    input  logic                  int_pending,
    input  logic                  fetch_ready,
    output logic [PIPE_WIDTH-1:0] flush,
    output logic [PIPE_WIDTH-1:0] pause,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  idle_wake,
    output logic                  busy
);

    localparam int CNT_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_HOLD - 1);

    redirect_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [PIPE_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PIPE_WIDTH-1:0] flush_q, flush_d;
    logic [PIPE_WIDTH-1:0] pause_q, pause_d;
    logic                  rv_q, rv_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  wake_q, wake_d;
    logic                  busy_q, busy_d;

    logic                  pick_valid;
    redirect_cause_t       pick_cause;
    logic [ADDR_WIDTH-1:0] pick_target;
    logic                  override;

    // Branches are wrong-path once a redirect is in progress, so only RUN may pick them.
    redirect_prio_enc #(.ADDR_WIDTH(ADDR_WIDTH)) u_prio (
        .exc_req       (exc_req),
        .exc_target    (exc_target),
        .ertn_req      (ertn_req),
        .ertn_target   (ertn_target),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .branch_en     (state_q == RUN),
        .pick_valid    (pick_valid),
        .pick_cause    (pick_cause),
        .pick_target   (pick_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            target_q <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            flush_q  <= '0;
            pause_q  <= '0;
            rv_q     <= 1'b0;
            pc_q     <= '0;
            wake_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            pause_q  <= pause_d;
            rv_q     <= rv_d;
            pc_q     <= pc_d;
            wake_q   <= wake_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        override = 1'b0;
        unique case (state_q)
            RUN: begin
                if (pick_valid) override = 1'b1;
                else if (idle_req) state_d = IDLE;
            end
            FLUSH: begin
                if (exc_req || ertn_req) override = 1'b1;
                else if (cnt_q == '0) state_d = REDIRECT;
                else cnt_d = cnt_q - 1'b1;
            end
            REDIRECT: begin
                // An exception accepted alongside fetch_ready still wins; a plain ertn only
                // overrides while fetch has not taken the current redirect.
                if (exc_req || (ertn_req && !fetch_ready)) override = 1'b1;
                else if (fetch_ready) state_d = RUN;
            end
            IDLE: begin
                if (exc_req) override = 1'b1;
                else if (int_pending) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (override) begin
            state_d  = FLUSH;
            target_d = pick_target;
            mask_d   = PIPE_WIDTH'(cause_mask(pick_cause));
            cnt_d    = CNT_RELOAD;
        end
    end

    // Outputs derive from the next state only, so flush and redirect_valid never overlap.
    always_comb begin
        flush_d = (state_d == FLUSH) ? mask_d : '0;
        pause_d = (state_d == IDLE) ? PIPE_WIDTH'(PAUSE_MASK_IDLE) : '0;
        rv_d    = (state_d == REDIRECT);
        pc_d    = (state_d == REDIRECT) ? target_d : pc_q;
        wake_d  = (state_q == IDLE) && int_pending && (state_d != IDLE);
        busy_d  = (state_d != RUN);
    end

    assign flush          = flush_q;
    assign pause          = pause_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = pc_q;
    assign idle_wake      = wake_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_redirect_seq.sv
// Directed bench for redirect_seq with hand-computed expected values.
`timescale 1ns/1ps
module tb_redirect_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req, ertn_req, branch_req, idle_req, int_pending, fetch_ready;
    logic [31:0] exc_target, ertn_target, branch_target;
    logic [7:0]  flush, pause;
    logic        redirect_valid, idle_wake, busy;
    logic [31:0] redirect_pc;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    redirect_seq #(.PIPE_WIDTH(8), .ADDR_WIDTH(32), .FLUSH_HOLD(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exc_req        (exc_req),
        .exc_target     (exc_target),
        .ertn_req       (ertn_req),
        .ertn_target    (ertn_target),
        .branch_req     (branch_req),
        .branch_target  (branch_target),
        .idle_req       (idle_req),
        .int_pending    (int_pending),
        .fetch_ready    (fetch_ready),
        .flush          (flush),
        .pause          (pause),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .idle_wake      (idle_wake),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        exc_req = 0; ertn_req = 0; branch_req = 0; idle_req = 0;
        int_pending = 0; fetch_ready = 0;
        exc_target = '0; ertn_target = '0; branch_target = '0;
        tick(); tick();
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_pause", 32'(pause), 32'h0);
        chk("rst_rv", 32'(redirect_valid), 32'h0);
        chk("rst_pc", redirect_pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wake", 32'(idle_wake), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("run_idle_busy", 32'(busy), 32'h0);

        // Branch only: 0x1F for two cycles, then one redirect cycle
        branch_req = 1; branch_target = 32'h1c000100; fetch_ready = 1;
        tick();
        branch_req = 0;
        chk("br_flush1", 32'(flush), 32'h1F);
        chk("br_busy1", 32'(busy), 32'h1);
        chk("br_rv1", 32'(redirect_valid), 32'h0);
        tick();
        chk("br_flush2", 32'(flush), 32'h1F);
        tick();
        chk("br_flush3", 32'(flush), 32'h0);
        chk("br_rv3", 32'(redirect_valid), 32'h1);
        chk("br_pc3", redirect_pc, 32'h1c000100);
        tick();
        chk("br_rv4", 32'(redirect_valid), 32'h0);
        chk("br_busy4", 32'(busy), 32'h0);

        // Exception overrides branch during FLUSH and reloads the counter
        branch_req = 1; branch_target = 32'h1c000100;
        tick();
        branch_req = 0;
        chk("ov_flush_br", 32'(flush), 32'h1F);
        exc_req = 1; exc_target = 32'h1c008000;
        tick();
        exc_req = 0;
        chk("ov_flush_full1", 32'(flush), 32'h7F);
        tick();
        chk("ov_flush_full2", 32'(flush), 32'h7F);
        chk("ov_rv_low", 32'(redirect_valid), 32'h0);
        tick();
        chk("ov_flush_done", 32'(flush), 32'h0);
        chk("ov_rv", 32'(redirect_valid), 32'h1);
        chk("ov_pc", redirect_pc, 32'h1c008000);
        tick();
        chk("ov_rv_drop", 32'(redirect_valid), 32'h0);

        // Fetch backpressure: redirect held 4 cycles with stable pc
        fetch_ready = 0;
        ertn_req = 1; ertn_target = 32'h1c000444;
        tick();
        ertn_req = 0;
        chk("bp_flush1", 32'(flush), 32'h7F);
        tick();
        chk("bp_flush2", 32'(flush), 32'h7F);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_rv_hold", 32'(redirect_valid), 32'h1);
            chk("bp_pc_hold", redirect_pc, 32'h1c000444);
            chk("bp_flush_zero", 32'(flush), 32'h0);
            tick();
        end
        chk("bp_rv_last", 32'(redirect_valid), 32'h1);
        chk("bp_pc_last", redirect_pc, 32'h1c000444);
        fetch_ready = 1;
        tick();
        chk("bp_rv_drop", 32'(redirect_valid), 32'h0);
        chk("bp_busy_drop", 32'(busy), 32'h0);

        // Idle wake on interrupt after five paused cycles
        fetch_ready = 0;
        idle_req = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("idle_pause", 32'(pause), 32'h7F);
            chk("idle_flush", 32'(flush), 32'h0);
            chk("idle_wake_lo", 32'(idle_wake), 32'h0);
            if (i < 4) tick();
        end
        idle_req = 0;
        int_pending = 1;
        tick();
        int_pending = 0;
        chk("wake_pulse", 32'(idle_wake), 32'h1);
        chk("wake_pause", 32'(pause), 32'h0);
        chk("wake_busy", 32'(busy), 32'h0);
        tick();
        chk("wake_once", 32'(idle_wake), 32'h0);

        // Idle with exception and interrupt together
        idle_req = 1;
        tick();
        idle_req = 0;
        chk("ie_pause", 32'(pause), 32'h7F);
        exc_req = 1; int_pending = 1; exc_target = 32'h1c00a000;
        tick();
        exc_req = 0; int_pending = 0;
        chk("ie_wake", 32'(idle_wake), 32'h1);
        chk("ie_pause_clr", 32'(pause), 32'h0);
        chk("ie_flush1", 32'(flush), 32'h7F);
        chk("ie_busy", 32'(busy), 32'h1);
        tick();
        chk("ie_wake_once", 32'(idle_wake), 32'h0);
        chk("ie_flush2", 32'(flush), 32'h7F);
        tick();
        chk("ie_rv", 32'(redirect_valid), 32'h1);
        chk("ie_pc", redirect_pc, 32'h1c00a000);

        // Exception arriving with fetch_ready in REDIRECT wins
        exc_req = 1; exc_target = 32'h1c00c000; fetch_ready = 1;
        tick();
        exc_req = 0; fetch_ready = 0;
        chk("rx_rv_drop", 32'(redirect_valid), 32'h0);
        chk("rx_flush", 32'(flush), 32'h7F);
        tick(); tick();
        chk("rx_rv", 32'(redirect_valid), 32'h1);
        chk("rx_pc", redirect_pc, 32'h1c00c000);

        // Async reset while redirect_valid is high
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rv", 32'(redirect_valid), 32'h0);
        chk("ar_flush", 32'(flush), 32'h0);
        chk("ar_pause", 32'(pause), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("ar_run_busy", 32'(busy), 32'h0);
        chk("ar_run_rv", 32'(redirect_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
